// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: opcodes, ALU-op classes and the
// bundled control word carried from decode into execute.
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd1;
    localparam logic [5:0] OP_SW    = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd3;
    localparam logic [5:0] OP_ADDI  = 6'd4;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BEQ = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detection: decides which decode specifiers are real sources
// and flags a match against a load currently occupying EX.
module load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 6
) (
    input  logic [OPCODE_W-1:0]   id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  stall_o
);

    logic rs_used;
    logic rt_used;

    // Unknown opcodes are treated as rs-only so they can never stall on rt.
    always_comb begin
        rs_used = 1'b1;
        rt_used = 1'b0;
        case (id_opcode)
            OPCODE_W'(OP_RTYPE),
            OPCODE_W'(OP_SW),
            OPCODE_W'(OP_BEQ): rt_used = 1'b1;
            default:           rt_used = 1'b0;
        endcase
    end

    assign stall_o = ex_valid & ex_mem_read & (ex_rt != '0) &
                     ((rs_used & (id_rs == ex_rt)) | (rt_used & (id_rt == ex_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional performance counters are built when ID_EX_PERF_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_W-1:0]   id_opcode,
    input  logic                  id_reg_dst,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic [1:0]            id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rdata1,
    input  logic [DATA_W-1:0]     id_rdata2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic                  flush_i,
    input  logic                  ex_hold_i,
    output logic                  ex_valid,
    output logic                  ex_reg_dst,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic [1:0]            ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_rdata1,
    output logic [DATA_W-1:0]     ex_rdata2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic                  stall_o,
    output logic                  pc_write_o,
    output logic                  if_id_write_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  bubble;

    assign id_ctrl = '{reg_dst:    id_reg_dst,
                       branch:     id_branch,
                       mem_read:   id_mem_read,
                       mem_to_reg: id_mem_to_reg,
                       mem_write:  id_mem_write,
                       alu_src:    id_alu_src,
                       reg_write:  id_reg_write,
                       alu_op:     id_alu_op};

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .OPCODE_W   (OPCODE_W)
    ) u_load_use_detect (
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rt       (ex_rt),
        .stall_o     (stall_o)
    );

    assign pc_write_o    = ~stall_o & ~ex_hold_i;
    assign if_id_write_o = ~stall_o & ~ex_hold_i;
    assign bubble        = flush_i | stall_o;

    // Bubbles clear only valid and control; specifiers and data still load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_pc4    <= '0;
        end else if (!ex_hold_i) begin
            ex_valid  <= ~bubble;
            ex_ctrl   <= bubble ? ctrl_t'('0) : id_ctrl;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc4    <= id_pc4;
        end
    end

    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_alu_op     = ex_ctrl.alu_op;

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (!ex_hold_i) begin
            if (stall_o) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_i) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (perf counters checked when
// ID_EX_PERF_EN is defined).
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  id_opcode;
    ctrl_t       id_c;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic        flush_i, ex_hold_i;
    logic        ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic        ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]  ex_alu_op;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic        stall_o, pc_write_o, if_id_write_o;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    localparam ctrl_t C_LW   = '{reg_dst:1'b0, branch:1'b0, mem_read:1'b1, mem_to_reg:1'b1,
                                 mem_write:1'b0, alu_src:1'b1, reg_write:1'b1, alu_op:2'b00};
    localparam ctrl_t C_R    = '{reg_dst:1'b1, branch:1'b0, mem_read:1'b0, mem_to_reg:1'b0,
                                 mem_write:1'b0, alu_src:1'b0, reg_write:1'b1, alu_op:2'b10};
    localparam ctrl_t C_SW   = '{reg_dst:1'b0, branch:1'b0, mem_read:1'b0, mem_to_reg:1'b0,
                                 mem_write:1'b1, alu_src:1'b1, reg_write:1'b0, alu_op:2'b00};
    localparam ctrl_t C_BEQ  = '{reg_dst:1'b0, branch:1'b1, mem_read:1'b0, mem_to_reg:1'b0,
                                 mem_write:1'b0, alu_src:1'b0, reg_write:1'b0, alu_op:2'b01};
    localparam ctrl_t C_ADDI = '{reg_dst:1'b0, branch:1'b0, mem_read:1'b0, mem_to_reg:1'b0,
                                 mem_write:1'b0, alu_src:1'b1, reg_write:1'b1, alu_op:2'b00};

    id_ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_opcode     (id_opcode),
        .id_reg_dst    (id_c.reg_dst),
        .id_branch     (id_c.branch),
        .id_mem_read   (id_c.mem_read),
        .id_mem_to_reg (id_c.mem_to_reg),
        .id_mem_write  (id_c.mem_write),
        .id_alu_src    (id_c.alu_src),
        .id_reg_write  (id_c.reg_write),
        .id_alu_op     (id_c.alu_op),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_rdata1     (id_rdata1),
        .id_rdata2     (id_rdata2),
        .id_imm        (id_imm),
        .id_pc4        (id_pc4),
        .flush_i       (flush_i),
        .ex_hold_i     (ex_hold_i),
        .ex_valid      (ex_valid),
        .ex_reg_dst    (ex_reg_dst),
        .ex_branch     (ex_branch),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_write  (ex_mem_write),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_write  (ex_reg_write),
        .ex_alu_op     (ex_alu_op),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .ex_rdata1     (ex_rdata1),
        .ex_rdata2     (ex_rdata2),
        .ex_imm        (ex_imm),
        .ex_pc4        (ex_pc4),
        .stall_o       (stall_o),
        .pc_write_o    (pc_write_o),
        .if_id_write_o (if_id_write_o)
`ifdef ID_EX_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input ctrl_t c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d);
        id_opcode = op;
        id_c      = c;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_rdata1 = d;
        id_rdata2 = ~d;
        id_imm    = d + 32'd1;
        id_pc4    = d + 32'd4;
        #1;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(ex_valid), 64'd0);
        chk({tag, "_ctrl"}, 64'({ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
                                 ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op}), 64'd0);
        chk({tag, "_spec"}, 64'({ex_rs, ex_rt, ex_rd}), 64'd0);
        chk({tag, "_data"}, {ex_rdata1, ex_rdata2} | {ex_imm, ex_pc4}, 64'd0);
    endtask

    task automatic chk_ctrl(input string tag, input ctrl_t exp);
        chk(tag, 64'({ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
                      ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op}), 64'(exp));
    endtask

    initial begin
        reset     = 1'b1;
        flush_i   = 1'b0;
        ex_hold_i = 1'b0;
        drive(OP_LW, C_LW, 5'd2, 5'd5, 5'd0, 32'h100);
        #2;
        chk_all_zero("por");
        chk("por_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: asynchronous reset with a valid instruction in EX
        tick();
        chk("t1_valid_before", 64'(ex_valid), 64'd1);
        chk("t1_rdata1_before", 64'(ex_rdata1), 64'h100);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("t1_async");
        chk("t1_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 2: LW r5 then dependent RType on rs
        tick();
        chk("t2_lw_rt", 64'(ex_rt), 64'd5);
        chk("t2_lw_memrd", 64'(ex_mem_read), 64'd1);
        drive(OP_RTYPE, C_R, 5'd5, 5'd6, 5'd7, 32'h200);
        chk("t2_stall", 64'(stall_o), 64'd1);
        chk("t2_pcw", 64'(pc_write_o), 64'd0);
        chk("t2_ifidw", 64'(if_id_write_o), 64'd0);
        tick();
        chk("t2_bub_valid", 64'(ex_valid), 64'd0);
        chk_ctrl("t2_bub_ctrl", '0);
        chk("t2_bub_rs", 64'(ex_rs), 64'd5);
        chk("t2_stall_drop", 64'(stall_o), 64'd0);
        chk("t2_pcw_back", 64'(pc_write_o), 64'd1);
        tick();
        chk("t2_r_valid", 64'(ex_valid), 64'd1);
        chk("t2_r_regwr", 64'(ex_reg_write), 64'd1);
        chk("t2_r_aluop", 64'(ex_alu_op), 64'(ALUOP_R));
        chk("t2_r_rd", 64'(ex_rd), 64'd7);
        chk("t2_r_data", {ex_rdata1, ex_rdata2}, {32'h200, 32'hFFFF_FDFF});
        chk("t2_r_imm_pc4", {ex_imm, ex_pc4}, {32'h201, 32'h204});

        // Test 3: LW r5 then ADDI with rt=5 (rt is not a source)
        drive(OP_LW, C_LW, 5'd1, 5'd5, 5'd0, 32'h300);
        chk("t3_nostall_lw", 64'(stall_o), 64'd0);
        tick();
        drive(OP_ADDI, C_ADDI, 5'd3, 5'd5, 5'd0, 32'h310);
        chk("t3_stall", 64'(stall_o), 64'd0);
        chk("t3_pcw", 64'(pc_write_o), 64'd1);
        tick();
        chk("t3_valid", 64'(ex_valid), 64'd1);
        chk_ctrl("t3_ctrl", C_ADDI);
        chk("t3_rt", 64'(ex_rt), 64'd5);

        // Test 4: LW r0 never creates a hazard
        drive(OP_LW, C_LW, 5'd1, 5'd0, 5'd0, 32'h400);
        tick();
        drive(OP_SW, C_SW, 5'd0, 5'd0, 5'd0, 32'h410);
        chk("t4_stall_r0", 64'(stall_o), 64'd0);

        // SW depends through rt; unknown opcode ignores rt
        drive(OP_LW, C_LW, 5'd1, 5'd5, 5'd0, 32'h420);
        tick();
        drive(6'd7, C_ADDI, 5'd1, 5'd5, 5'd0, 32'h430);
        chk("t4_unknown_rt", 64'(stall_o), 64'd0);
        drive(6'd7, C_ADDI, 5'd5, 5'd1, 5'd0, 32'h430);
        chk("t4_unknown_rs", 64'(stall_o), 64'd1);
        drive(OP_SW, C_SW, 5'd1, 5'd5, 5'd0, 32'h440);
        chk("t4_sw_rt", 64'(stall_o), 64'd1);
        tick();
        chk("t4_bub_valid", 64'(ex_valid), 64'd0);
        tick();
        chk("t4_sw_valid", 64'(ex_valid), 64'd1);
        chk_ctrl("t4_sw_ctrl", C_SW);

        // Test 5: flush a BEQ, then flush under hold is ignored
        drive(OP_BEQ, C_BEQ, 5'd1, 5'd2, 5'd0, 32'h500);
        flush_i = 1'b1;
        tick();
        chk("t5_flush_valid", 64'(ex_valid), 64'd0);
        chk("t5_flush_branch", 64'(ex_branch), 64'd0);
        flush_i = 1'b0;
        tick();
        chk("t5_beq_valid", 64'(ex_valid), 64'd1);
        chk_ctrl("t5_beq_ctrl", C_BEQ);
        drive(OP_ADDI, C_ADDI, 5'd9, 5'd10, 5'd0, 32'h510);
        flush_i   = 1'b1;
        ex_hold_i = 1'b1;
        #1;
        chk("t5_hold_pcw", 64'(pc_write_o), 64'd0);
        tick();
        chk("t5_hold_valid", 64'(ex_valid), 64'd1);
        chk_ctrl("t5_hold_ctrl", C_BEQ);
        chk("t5_hold_data", 64'(ex_rdata1), 64'h500);
        flush_i   = 1'b0;
        ex_hold_i = 1'b0;

        // Test 6: hold for 3 cycles while a hazard is present
        drive(OP_LW, C_LW, 5'd1, 5'd5, 5'd0, 32'h600);
        tick();
        drive(OP_RTYPE, C_R, 5'd5, 5'd2, 5'd8, 32'h610);
        ex_hold_i = 1'b1;
        #1;
`ifdef ID_EX_PERF_EN
        chk("t6_perf_stall_pre", 64'(perf_stall_cnt), 64'd2);
        chk("t6_perf_flush", 64'(perf_flush_cnt), 64'd1);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_valid", 64'(ex_valid), 64'd1);
            chk_ctrl("t6_hold_ctrl", C_LW);
            chk("t6_hold_rdata1", 64'(ex_rdata1), 64'h600);
            chk("t6_hold_stall", 64'(stall_o), 64'd1);
            chk("t6_hold_pcw", 64'(pc_write_o), 64'd0);
`ifdef ID_EX_PERF_EN
            chk("t6_perf_hold", 64'(perf_stall_cnt), 64'd2);
`endif
        end
        ex_hold_i = 1'b0;
        tick();
        chk("t6_bub_valid", 64'(ex_valid), 64'd0);
`ifdef ID_EX_PERF_EN
        chk("t6_perf_after", 64'(perf_stall_cnt), 64'd3);
`endif
        tick();
        chk("t6_r_valid", 64'(ex_valid), 64'd1);
        chk_ctrl("t6_r_ctrl", C_R);
        chk("t6_r_rd", 64'(ex_rd), 64'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage core, plus load-use hazard detection.
- Sits between decode (register file, sign-extender, control unit) and execute (ALU control, ALU, branch compare).
- Captures decoded control and operands each cycle.
- Detects a load-use hazard against the instruction already in EX and, when one exists, inserts a one-cycle bubble and freezes PC and IF/ID.
- Supports flush (taken branch) and hold (downstream back-pressure).

Parameters:
DATA_W, 32, operand / immediate / PC width
REG_ADDR_W, 5, register specifier width
OPCODE_W, 6, opcode width

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
id_opcode  in  OPCODE_W  decode opcode (RType=0, LW=1, SW=2, BEQ=3, ADDI=4)
id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decode control
id_alu_op  in  2  decode ALU op class
id_rs, id_rt, id_rd  in  REG_ADDR_W  register specifiers
id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W  operands, sign-extended immediate, PC+4
flush_i  in  1  kill instruction entering EX (taken branch)
ex_hold_i  in  1  downstream stall; freeze ID/EX
ex_valid  out  1  EX slot holds a real instruction
ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered control
ex_alu_op  out  2  registered ALU op
ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  registered specifiers
ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data
stall_o  out  1  load-use hazard present (combinational)
pc_write_o, if_id_write_o  out  1  upstream write enables (combinational)

Behaviour:
- Reset: all ex_* outputs are 0, including ex_valid and ex_alu_op=2'b00. Asynchronous assert; release is synchronous to clk.
- Reset mid-operation discards the EX contents. No state survives reset.
- Source use by opcode:
  - rs_used = 1 for all five opcodes.
  - rt_used = 1 for RType, SW and BEQ only.
  - Unknown opcodes: rs_used=1, rt_used=0.
- stall_o = ex_valid & ex_mem_read & (ex_rt != 0) & ((rs_used & id_rs == ex_rt) | (rt_used & id_rt == ex_rt)).
- Register 0 never creates a hazard.
- pc_write_o = if_id_write_o = ~stall_o & ~ex_hold_i.
- Per-posedge update, highest priority first:
  1. ex_hold_i=1: all ex_* hold. flush_i is ignored that cycle; the branch unit re-asserts it.
  2. flush_i=1: bubble.
  3. stall_o=1: bubble.
  4. Otherwise: capture all id_* fields; ex_valid=1.
- Bubble:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_dst and ex_alu_src go to 0; ex_alu_op goes to 2'b00.
  - Specifier and data fields still capture the id_* values, so the bubble is deterministic but don't-care.
- Latency: 1 cycle from ID to EX.
- A load-use pair costs exactly one bubble. After the bubble, ex_valid=0, so stall_o drops and the consumer is captured on the next edge.
- Back-to-back loads into the same register stall once per consumer.
- flush_i together with stall_o: a bubble results. pc_write_o still follows stall_o, and the fetch redirect is owned by the branch unit.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt and perf_flush_cnt, each 32 bits.
  - perf_stall_cnt increments on each edge where stall_o=1 and ex_hold_i=0.
  - perf_flush_cnt increments on each edge where flush_i=1 and ex_hold_i=0.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI;
  - ALU-op constants ALUOP_MEM=2'b00, ALUOP_BEQ=2'b01, ALUOP_R=2'b10;
  - a packed ctrl_t struct bundling the 8 control fields.
- One sub-module, load_use_detect: the combinational rs_used/rt_used decode and stall_o equation. It is reused by later forwarding work.

Test Plan:
1. Reset asserted mid-run with ex_valid=1 -> all ex_* outputs are 0 immediately (asynchronous) and stall_o=0.
2. LW r5 in EX (ex_mem_read=1, ex_rt=5); decode RType with id_rs=5 -> stall_o=1, pc_write_o=0. Next edge: ex_valid=0 and all control 0. Following edge: the RType is captured with ex_reg_write=1 and ex_alu_op=2'b10.
3. LW r5 in EX; decode ADDI with id_rt=5, id_rs=3 -> stall_o=0 (rt not a source); ADDI captured with ex_alu_src=1.
4. LW r0 in EX; decode SW with id_rt=0 -> stall_o=0.
5. flush_i=1 with a valid BEQ in decode -> next edge ex_valid=0 and ex_branch=0. With ex_hold_i=1 at the same time -> EX contents unchanged.
6. ex_hold_i=1 for 3 cycles while a hazard is present -> ex_* stable, pc_write_o=0. With ID_EX_PERF_EN, perf_stall_cnt is unchanged until the hold drops, then increments by 1.
